// File: rtl/im_loader.sv
// im_loader: boot-time writer for the SISC instruction memory.
// Receives a byte stream (header count, big-endian words, checksum byte),
// writes each assembled word to the im write port at consecutive addresses,
// and releases the core reset only after the checksum matches.
module im_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        reload,
  output logic [15:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        im_we,
  output logic        cpu_rst_f,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      r_state;
  logic        r_rx_ready;
  logic [15:0] r_im_addr;
  logic [31:0] r_im_wdata;
  logic        r_im_we;
  logic        r_cpu_rst_f;
  logic        r_done;
  logic        r_err;
  logic [15:0] r_words_loaded;
  logic [15:0] r_count;
  logic [7:0]  r_cnt_hi;
  logic [15:0] r_addr;   // next address to write; im_addr only follows it on a write
  logic [23:0] r_shift;  // first three bytes of the word being assembled
  logic [1:0]  r_idx;
  logic [7:0]  r_csum;

  logic        w_xfer;
  logic        w_restart;
  logic [15:0] w_count;
  logic [15:0] w_words_next;

  assign w_xfer       = rx_valid && r_rx_ready;
  assign w_restart    = reload && (r_state == S_DONE || r_state == S_ERR);
  assign w_count      = {r_cnt_hi, rx_data};
  assign w_words_next = r_words_loaded + 16'd1;

  // Loader FSM and datapath; every output is a register updated here.
  // NOTE: all state uses non-blocking assignments so every register in this
  // block sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst || w_restart) begin
      r_state        <= S_HDR_HI;
      r_rx_ready     <= 1'b1;
      r_im_addr      <= BASE_ADDR;
      r_im_wdata     <= 32'h0;
      r_im_we        <= 1'b0;
      r_cpu_rst_f    <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_words_loaded <= 16'h0;
      r_count        <= 16'h0;
      r_cnt_hi       <= 8'h0;
      r_addr         <= BASE_ADDR;
      r_shift        <= 24'h0;
      r_idx          <= 2'd0;
      r_csum         <= 8'h0;
    end else begin
      case (r_state)
        S_HDR_HI: begin
          if (w_xfer) begin
            r_cnt_hi <= rx_data;
            r_state  <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (w_xfer) begin
            r_count <= w_count;
            if (w_count > MAX_WORDS) begin
              r_state    <= S_ERR;
              r_rx_ready <= 1'b0;
              r_err      <= 1'b1;
            end else if (w_count == 16'h0) begin
              r_state <= S_CHK;
            end else begin
              r_state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_csum  <= r_csum + rx_data;
            r_shift <= {r_shift[15:0], rx_data};
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_im_wdata <= {r_shift, rx_data};
              r_im_addr  <= r_addr;
              r_im_we    <= 1'b1;
              r_rx_ready <= 1'b0;
              r_state    <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          r_im_we        <= 1'b0;
          r_rx_ready     <= 1'b1;
          r_addr         <= r_addr + 16'd1;  // wraps FFFF -> 0000 by width
          r_words_loaded <= w_words_next;
          r_state        <= (w_words_next == r_count) ? S_CHK : S_DATA;
        end

        S_CHK: begin
          if (w_xfer) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_cpu_rst_f <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end

        S_DONE, S_ERR: begin
          // Terminal until reload or rst.
        end

        default: begin
          r_state    <= S_HDR_HI;
          r_rx_ready <= 1'b1;
        end
      endcase
    end
  end

  assign rx_ready     = r_rx_ready;
  assign im_addr      = r_im_addr;
  assign im_wdata     = r_im_wdata;
  assign im_we        = r_im_we;
  assign cpu_rst_f    = r_cpu_rst_f;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words_loaded;

endmodule
